and_gate: RTL and testbench
===========================

Name: and_gate

Overview:
- Parameterised bitwise AND unit used as a basic logic primitive in the RTL library.
- Provides a purely combinational AND output y = a & b, with zero latency and no dependence on clock or reset.
- Also provides a one-stage registered copy of y with a valid flag, a reduction flag, and a saturating activity counter for datapath and debug use.
- One clock domain; reset is asynchronous and active-high.

Parameters:
WIDTH, 1, bit width of a, b, y and y_q.
CNT_W, 16, width of the activity counter.

Ports:
clk  input  1  system clock; all registers update on the rising edge.
rst  input  1  asynchronous active-high reset.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
y  output  WIDTH  combinational a & b, bitwise.
in_valid  input  1  qualifies a/b for the registered path.
y_q  output  WIDTH  registered a & b.
out_valid  output  1  y_q holds a newly captured result.
y_all  output  1  combinational reduction-AND of y (1 only when every bit of y is 1).
hit_cnt  output  CNT_W  count of captured results with all bits 1.
clr_cnt  input  1  synchronous clear of hit_cnt.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- y = a & b per bit, purely combinational.
  - Settles in the same delta as any input change.
  - Unaffected by clk, rst or in_valid.
  - X/Z on an input bit propagates per Verilog & semantics. 0 & X = 0; 1 & X = X.
- y_all = &y, combinational. For WIDTH=1, y_all equals y.
- Reset (rst=1, asynchronous, takes effect immediately):
  - y_q = 0, out_valid = 0, hit_cnt = 0.
  - y and y_all stay combinational during reset.
- Registered path, 1-cycle latency:
  - At a rising clk edge with in_valid=1: y_q <= a & b, out_valid <= 1.
  - At an edge with in_valid=0: y_q holds its value, out_valid <= 0.
  - No back-pressure: every valid input is captured.
- hit_cnt, updated on each rising edge when not in reset:
  - If clr_cnt=1: hit_cnt <= 0. Clear wins over increment in the same cycle.
  - Else if in_valid=1 and &(a & b)=1: hit_cnt <= hit_cnt + 1, saturating at all-ones (no wrap).
- Reset asserted mid-operation: registered outputs clear immediately. The first capture after deassertion occurs at the first rising edge with rst=0 and in_valid=1.
- Truth table per bit: 00->0, 01->0, 10->0, 11->1.

Test Plan:
- Combinational truth table, WIDTH=1, no clock activity. Apply a=0,b=0 at t=3; b=1 at t=6; a=1,b=0 at t=9; b=1 at t=12. Required: y = 0,0,0,1 at each step, valid immediately. y_all tracks y.
- X propagation: before any drive, a=b=X gives y=X. Then a=0, b=X gives y=0; a=1, b=X gives y=X.
- Registered path, WIDTH=8: rst pulse, then in_valid=1 with a=8'hF0, b=8'h3C. Required: next edge y_q=8'h30, out_valid=1. Following edge with in_valid=0: y_q=8'h30, out_valid=0.
- Counter: three valid cycles with a=b=8'hFF, plus one valid cycle with a=8'hFF, b=8'hFE. Required: hit_cnt=3. Asserting clr_cnt together with a hit in the same cycle gives hit_cnt=0.
- Saturation, CNT_W=2: five consecutive all-ones valid cycles. Required: hit_cnt stops at 3 and does not wrap.
- Asynchronous reset mid-stream: assert rst between clock edges while out_valid=1 and hit_cnt=2. Required: y_q=0, out_valid=0, hit_cnt=0 immediately, with no clock edge needed. y still equals a & b throughout.

Source files
------------

// File: rtl/and_gate_if.sv
// rtl/and_gate_if.sv - operand/result bundle for the and_gate primitive
interface and_gate_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y;
    logic             in_valid;
    logic [WIDTH-1:0] y_q;
    logic             out_valid;
    logic             y_all;
    logic [CNT_W-1:0] hit_cnt;
    logic             clr_cnt;

    modport master (
        output a, b, in_valid, clr_cnt,
        input  y, y_q, out_valid, y_all, hit_cnt
    );

    modport slave (
        input  a, b, in_valid, clr_cnt,
        output y, y_q, out_valid, y_all, hit_cnt
    );
endinterface

// File: rtl/and_gate.sv
// rtl/and_gate.sv - bitwise AND with registered copy, reduction flag and saturating hit counter
module and_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    and_gate_if.slave  bus
);
    logic [WIDTH-1:0] w_y;
    logic             w_all;
    logic             w_hit;
    logic             w_sat;

    logic [WIDTH-1:0] r_y_q;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_hit_cnt;

    assign w_y   = bus.a & bus.b;
    assign w_all = &w_y;
    assign w_hit = bus.in_valid & w_all;
    assign w_sat = &r_hit_cnt;

    // y_q only updates on valid input; out_valid marks the cycle after a capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y_q       <= '0;
            r_out_valid <= 1'b0;
            r_hit_cnt   <= '0;
        end else begin
            if (bus.in_valid) begin
                r_y_q <= w_y;
            end
            r_out_valid <= bus.in_valid;
            if (bus.clr_cnt) begin
                r_hit_cnt <= '0;
            end else if (w_hit && !w_sat) begin
                r_hit_cnt <= r_hit_cnt + 1'b1;
            end
        end
    end

    assign bus.y         = w_y;
    assign bus.y_all     = w_all;
    assign bus.y_q       = r_y_q;
    assign bus.out_valid = r_out_valid;
    assign bus.hit_cnt   = r_hit_cnt;
endmodule

// File: tb/tb_and_gate.sv
// tb/tb_and_gate.sv - self-checking bench for and_gate across three parameter sets
module tb_and_gate;
    logic clk      = 1'b0;
    logic clk_idle = 1'b0;
    logic rst1     = 1'b0;
    logic rst2     = 1'b1;
    logic rst3     = 1'b1;

    always #5 clk = ~clk;

    and_gate_if #(.WIDTH(1), .CNT_W(16)) if1 ();
    and_gate_if #(.WIDTH(8), .CNT_W(16)) if2 ();
    and_gate_if #(.WIDTH(4), .CNT_W(2))  if3 ();

    and_gate #(.WIDTH(1), .CNT_W(16)) u_w1  (.clk(clk_idle), .rst(rst1), .bus(if1));
    and_gate #(.WIDTH(8), .CNT_W(16)) u_w8  (.clk(clk),      .rst(rst2), .bus(if2));
    and_gate #(.WIDTH(4), .CNT_W(2))  u_sat (.clk(clk),      .rst(rst3), .bus(if3));

    int n_chk  = 0;
    int n_fail = 0;

    // reference state for the WIDTH=8 instance
    logic [7:0] m_yq;
    logic       m_ov;
    int         m_cnt;

    typedef struct {
        logic a;
        logic b;
        logic y;
    } vec_t;
    vec_t tt[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step2(input logic [7:0] a, input logic [7:0] b,
                         input logic iv, input logic clr, input string tag);
        logic [7:0] p;
        p = a & b;
        if2.a        = a;
        if2.b        = b;
        if2.in_valid = iv;
        if2.clr_cnt  = clr;
        #1;
        chk({tag, "_y"},     {24'h0, if2.y},  {24'h0, p});
        chk({tag, "_y_all"}, {31'h0, if2.y_all}, {31'h0, (p == 8'hFF)});
        @(posedge clk);
        if (iv) m_yq = p;
        m_ov = iv;
        if (clr) m_cnt = 0;
        else if (iv && p == 8'hFF) m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
        #1;
        chk({tag, "_y_q"},       {24'h0, if2.y_q},     {24'h0, m_yq});
        chk({tag, "_out_valid"}, {31'h0, if2.out_valid}, {31'h0, m_ov});
        chk({tag, "_hit_cnt"},   {16'h0, if2.hit_cnt}, m_cnt);
    endtask

    initial begin
        logic       xb;
        logic       ex;
        logic [7:0] ra;
        logic [7:0] rb;

        tt[0] = '{a: 1'b0, b: 1'b0, y: 1'b0};
        tt[1] = '{a: 1'b0, b: 1'b1, y: 1'b0};
        tt[2] = '{a: 1'b1, b: 1'b0, y: 1'b0};
        tt[3] = '{a: 1'b1, b: 1'b1, y: 1'b1};

        if2.a = 8'hFF; if2.b = 8'hFF; if2.in_valid = 1'b1; if2.clr_cnt = 1'b0;
        if3.a = 4'h0;  if3.b = 4'h0;  if3.in_valid = 1'b0; if3.clr_cnt = 1'b0;
        if1.in_valid = 1'b0; if1.clr_cnt = 1'b0;

        // undriven operands: y follows a & b including unknowns
        #1;
        ex = if1.a & if1.b;
        chk("x_undriven_y", {31'h0, if1.y}, {31'h0, ex});
        #2;

        // truth table at t=3,6,9,12 with no clock on this instance
        for (int i = 0; i < 4; i++) begin
            if1.a = tt[i].a;
            if1.b = tt[i].b;
            #1;
            chk($sformatf("tt%0d_y", i),     {31'h0, if1.y},     {31'h0, tt[i].y});
            chk($sformatf("tt%0d_y_all", i), {31'h0, if1.y_all}, {31'h0, tt[i].y});
            #2;
        end

        xb = 1'bx;
        if1.a = 1'b0; if1.b = xb;
        #1;
        chk("x_a0_y", {31'h0, if1.y}, 32'h0);
        if1.a = 1'b1; if1.b = xb;
        ex = 1'b1 & xb;
        #1;
        chk("x_a1_y", {31'h0, if1.y}, {31'h0, ex});

        rst1 = 1'b1;
        if1.a = 1'b1; if1.b = 1'b1;
        #1;
        chk("rst_comb_y",     {31'h0, if1.y},     32'h1);
        chk("rst_comb_y_all", {31'h0, if1.y_all}, 32'h1);
        if1.b = 1'b0;
        #1;
        chk("rst_comb_y0", {31'h0, if1.y}, 32'h0);

        // reset held across an edge with valid all-ones input
        @(posedge clk); #1;
        chk("rst_y_q",       {24'h0, if2.y_q},       32'h0);
        chk("rst_out_valid", {31'h0, if2.out_valid}, 32'h0);
        chk("rst_hit_cnt",   {16'h0, if2.hit_cnt},   32'h0);
        rst2 = 1'b0;
        m_yq = 8'h00; m_ov = 1'b0; m_cnt = 0;

        step2(8'hF0, 8'h3C, 1'b1, 1'b0, "reg_cap");
        chk("reg_cap_30", {24'h0, if2.y_q}, 32'h30);
        step2(8'hFF, 8'hFF, 1'b0, 1'b0, "reg_hold");
        chk("reg_hold_30", {24'h0, if2.y_q}, 32'h30);

        for (int i = 0; i < 3; i++) step2(8'hFF, 8'hFF, 1'b1, 1'b0, "cnt_hit");
        step2(8'hFF, 8'hFE, 1'b1, 1'b0, "cnt_miss");
        chk("cnt_three", {16'h0, if2.hit_cnt}, 32'd3);
        step2(8'hFF, 8'hFF, 1'b1, 1'b1, "cnt_clr_wins");
        chk("cnt_clr_zero", {16'h0, if2.hit_cnt}, 32'd0);

        // async reset between edges with out_valid=1 and hit_cnt=2
        step2(8'hFF, 8'hFF, 1'b1, 1'b0, "mid_a");
        step2(8'hFF, 8'hFF, 1'b1, 1'b0, "mid_b");
        chk("mid_pre_cnt", {16'h0, if2.hit_cnt}, 32'd2);
        #3;
        if2.a = 8'hA5; if2.b = 8'h3C;
        rst2 = 1'b1;
        #1;
        chk("async_y_q",       {24'h0, if2.y_q},       32'h0);
        chk("async_out_valid", {31'h0, if2.out_valid}, 32'h0);
        chk("async_hit_cnt",   {16'h0, if2.hit_cnt},   32'h0);
        chk("async_y",         {24'h0, if2.y},         32'h24);
        m_yq = 8'h00; m_ov = 1'b0; m_cnt = 0;
        #2;
        rst2 = 1'b0;
        step2(8'h5A, 8'h0F, 1'b1, 1'b0, "post_rst");
        chk("post_rst_0a", {24'h0, if2.y_q}, 32'h0A);

        for (int i = 0; i < 200; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            step2(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), "rnd");
        end

        // saturation with a 2-bit counter
        @(negedge clk);
        rst3 = 1'b0;
        if3.a = 4'hF; if3.b = 4'hF; if3.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("sat%0d_hit_cnt", i), {30'h0, if3.hit_cnt}, (i + 1 > 3) ? 3 : i + 1);
            chk($sformatf("sat%0d_out_valid", i), {31'h0, if3.out_valid}, 32'h1);
        end
        chk("sat_y_q", {28'h0, if3.y_q}, 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
